field_setting_controller: RTL and testbench
===========================================

// Module: field_setting_controller
// PURPOSE
//  Parametrised multi-field value editor for the clock/alarm front panel. Generalises the hour/min/sec
//  setter to NUM_FIELDS fields, each with its own wrap limit. Adds up/down stepping, auto-repeat on a
//  held button, blink of the selected field, and confirm/cancel with a one-cycle commit strobe.
//  Sits between the debounced button layer and the timekeeper/alarm registers and the 7-seg driver.
// PARAMETERS
//  NUM_FIELDS   3           number of editable fields; field i occupies bits [i*FIELD_W +: FIELD_W]
//  FIELD_W      6           width of each field
//  FIELD_MAX    {6'd23,6'd59,6'd59}  packed per-field maximum (field 0 = LSBs = 59)
//  BLINK_HALF   25_000_000  clk cycles per blink half-period
//  REPEAT_DELAY 25_000_000  held cycles before the first auto-repeat step
//  REPEAT_RATE  5_000_000   cycles between subsequent auto-repeat steps
// PORTS
//  clk          in   1                       system clock, all logic on rising edge
//  rst_n        in   1                       asynchronous, active-low reset
//  btn_next     in   1                       debounced level; rise enters edit / selects next field
//  btn_inc      in   1                       debounced level; step selected field up (auto-repeat)
//  btn_dec      in   1                       debounced level; step selected field down (no repeat)
//  btn_confirm  in   1                       debounced level; rise commits edit
//  btn_cancel   in   1                       debounced level; rise discards edit
//  cur_val      in   NUM_FIELDS*FIELD_W      live value copied into edit buffer on edit entry
//  editing      out  1                       1 while in EDIT
//  sel          out  $clog2(NUM_FIELDS)      index of selected field
//  edit_val     out  NUM_FIELDS*FIELD_W      edit buffer, for display
//  set_val      out  NUM_FIELDS*FIELD_W      last committed value
//  set_valid    out  1                       one-cycle strobe; set_val updated this cycle
//  field_en     out  NUM_FIELDS              per-field display enable (0 = blanked)
// BEHAVIOUR
//  Reset: state IDLE, editing=0, sel=0, edit_val=0, set_val=0, set_valid=0, field_en all 1,
//   blink/repeat counters 0. Button history regs reset to 1, so a button held through reset gives no edge.
//  Edge detect: rise = btn & ~btn_q. Action registers on the first clk edge sampling the button high.
//  FSM IDLE: rise(btn_next) -> EDIT, edit_val<=cur_val, sel<=0. All other buttons ignored.
//  FSM EDIT, priority per cycle:
//   cancel > confirm > (inc/dec/next).
//   cancel -> IDLE, set_val unchanged, no strobe.
//   confirm -> IDLE, set_val<=edit_val, set_valid=1 next cycle only.
//   inc and dec rising together -> no step. next may still apply.
//   Step up: f>=MAX -> 0, else f+1. Step down: f==0 or f>MAX -> MAX, else f-1.
//   next + step same cycle: step applies to old sel, then sel advances. sel wraps NUM_FIELDS-1 -> 0.
//  Auto-repeat (inc only): hold counter h=0 on the rise cycle, +1 per cycle held. Extra step when
//   h==REPEAT_DELAY, then every REPEAT_RATE cycles while held. Release or sel change clears h.
//  Blink: in EDIT a free-running counter toggles phase every BLINK_HALF cycles.
//   field_en[sel]=0 in phase 1; all other bits 1.
//   Any step or next restarts the counter at phase 0 (selected field visible).
//   IDLE: field_en all 1, counter held at 0.
//  No arithmetic exceeds FIELD_W; counters are sized by $clog2 of their limits.
//  Async reset mid-edit aborts the edit with no strobe; all outputs return to reset values.
// TESTING (NUM_FIELDS=3, FIELD_MAX={23,59,59}, BLINK_HALF=4, REPEAT_DELAY=8, REPEAT_RATE=2)
//  1 cur_val={12,34,56}; next, inc, confirm -> edit_val={12,34,57}; set_valid high exactly 1 cycle;
//    set_val={12,34,57}; editing=0.
//  2 wrap: field0=59, inc -> 0; dec -> 59; sel=2 with 23, inc -> 0; next from sel=2 -> sel=0.
//  3 edit to {1,2,3}, cancel -> set_val unchanged, set_valid never asserted; confirm+cancel same cycle
//    -> cancel behaviour.
//  4 field0=0, hold inc sampled high 20 cycles -> steps at h=0,8,10,12,14,16,18 -> field0=7.
//  5 EDIT sel=1 idle -> field_en 3'b111 x4 cycles, 3'b101 x4, repeating; inc mid-phase-1 ->
//    3'b111 next cycle.
//  6 inc+dec same cycle -> no change; rst_n low mid-edit -> outputs at reset values; button held
//    across reset release -> no edge.

Source files
------------

// File: rtl/field_setting_controller.sv
// Multi-field value editor for the clock/alarm front panel: select a field, step it up/down with
// auto-repeat on inc, blink the selected field, then confirm (one-cycle commit strobe) or cancel.
module field_setting_controller #(
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W = 6,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX = {6'd23, 6'd59, 6'd59},
  parameter int BLINK_HALF = 25_000_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE = 5_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn_next,
  input  logic                          btn_inc,
  input  logic                          btn_dec,
  input  logic                          btn_confirm,
  input  logic                          btn_cancel,
  input  logic [NUM_FIELDS*FIELD_W-1:0] cur_val,
  output logic                          editing,
  output logic [$clog2(NUM_FIELDS)-1:0] sel,
  output logic [NUM_FIELDS*FIELD_W-1:0] edit_val,
  output logic [NUM_FIELDS*FIELD_W-1:0] set_val,
  output logic                          set_valid,
  output logic [NUM_FIELDS-1:0]         field_en
);

  localparam int SW = $clog2(NUM_FIELDS);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [HW-1:0] H_DELAY  = HW'(REPEAT_DELAY);
  // After the first repeat the counter is rewound so it re-hits H_DELAY every REPEAT_RATE cycles
  // (assumes REPEAT_RATE <= REPEAT_DELAY).
  localparam logic [HW-1:0] H_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE + 1);
  localparam logic [BW-1:0] B_LAST   = BW'(BLINK_HALF - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(NUM_FIELDS - 1);

  typedef enum logic {IDLE, EDIT} state_t;
  state_t state, state_nxt;

  logic [4:0] btn_now, btn_q, rise;
  logic rise_next, rise_inc, rise_dec, rise_confirm, rise_cancel;
  logic active, inc_held, rep_fire, step_up, step_dn, adv, commit;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;
  logic blink_phase;
  logic [FIELD_W-1:0] field_cur, field_max, field_nxt;

  assign btn_now = {btn_cancel, btn_confirm, btn_dec, btn_inc, btn_next};
  assign rise = btn_now & ~btn_q;
  assign {rise_cancel, rise_confirm, rise_dec, rise_inc, rise_next} = rise;

  assign active   = (state == EDIT) && !rise_cancel && !rise_confirm;
  assign commit   = (state == EDIT) && rise_confirm && !rise_cancel;
  assign inc_held = btn_inc & btn_q[1];
  assign rep_fire = active && inc_held && (hold_cnt == H_DELAY);
  assign step_up  = active && (rise_inc || rep_fire) && !rise_dec;
  assign step_dn  = active && rise_dec && !(rise_inc || rep_fire);
  assign adv      = active && rise_next;

  assign field_cur = edit_val[sel*FIELD_W +: FIELD_W];
  assign field_max = FIELD_MAX[sel*FIELD_W +: FIELD_W];

  always_comb begin
    field_nxt = field_cur;
    if (step_up)
      field_nxt = (field_cur >= field_max) ? '0 : field_cur + FIELD_W'(1);
    else if (step_dn)
      field_nxt = (field_cur == '0 || field_cur > field_max) ? field_max : field_cur - FIELD_W'(1);
  end

  // History starts at 1 so a button already held when reset releases produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '1;
    else        btn_q <= btn_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rise_next) state_nxt = EDIT;
      EDIT: if (rise_cancel || rise_confirm) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    editing  = (state == EDIT);
    field_en = '1;
    if (state == EDIT && blink_phase) field_en[sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edit_val  <= '0;
      set_val   <= '0;
      set_valid <= 1'b0;
      sel       <= '0;
    end else begin
      set_valid <= commit;
      if (commit) set_val <= edit_val;
      if (state == IDLE && rise_next) begin
        edit_val <= cur_val;
        sel      <= '0;
      end else if (active) begin
        if (step_up || step_dn) edit_val[sel*FIELD_W +: FIELD_W] <= field_nxt;
        if (adv) sel <= (sel == SEL_LAST) ? '0 : sel + SW'(1);
      end
    end
  end

  // hold_cnt holds the number of cycles inc has been held as seen on the current edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 hold_cnt <= '0;
    else if (!active || adv)    hold_cnt <= '0;
    else if (rise_inc)          hold_cnt <= HW'(1);
    else if (inc_held)          hold_cnt <= rep_fire ? H_RELOAD : hold_cnt + HW'(1);
    else                        hold_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!active || step_up || step_dn || adv) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == B_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_field_setting_controller.sv
// Scoreboard bench for field_setting_controller: stimulus queues expected commits and output
// snapshots; a negedge monitor pops and compares them against the DUT.
module tb_field_setting_controller;

  localparam int W = 18;
  localparam logic [4:0] B_NEXT = 5'b00001, B_INC = 5'b00010, B_DEC = 5'b00100,
                         B_CONF = 5'b01000, B_CANC = 5'b10000, B_NONE = 5'b00000;

  typedef struct {
    string      name;
    int         code;
    logic [W-1:0] exp;
  } probe_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_confirm = 1'b0, btn_cancel = 1'b0;
  logic [W-1:0] cur_val = '0;
  logic         editing;
  logic [1:0]   sel;
  logic [W-1:0] edit_val, set_val;
  logic         set_valid;
  logic [2:0]   field_en;

  int compared = 0;
  int mismatched = 0;
  probe_t       probes[$];
  logic [W-1:0] commits[$];
  logic         sv_prev = 1'b0;

  field_setting_controller #(
    .NUM_FIELDS(3), .FIELD_W(6), .FIELD_MAX({6'd23, 6'd59, 6'd59}),
    .BLINK_HALF(4), .REPEAT_DELAY(8), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
    .cur_val(cur_val), .editing(editing), .sel(sel), .edit_val(edit_val),
    .set_val(set_val), .set_valid(set_valid), .field_en(field_en)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input int f2, input int f1, input int f0);
    return {f2[5:0], f1[5:0], f0[5:0]};
  endfunction

  // Drive a button pattern and let n rising edges sample it; returns at posedge+2.
  task automatic applyStimulus(input logic [4:0] btns, input int n);
    {btn_cancel, btn_confirm, btn_dec, btn_inc, btn_next} = btns;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tap(input logic [4:0] btns);
    applyStimulus(btns, 1);
    applyStimulus(B_NONE, 1);
  endtask

  // code: 0 edit_val, 1 set_val, 2 sel, 3 editing, 4 field_en
  task automatic checkOutput(input string name, input int code, input logic [W-1:0] exp);
    probe_t p;
    p.name = name;
    p.code = code;
    p.exp  = exp;
    probes.push_back(p);
  endtask

  always @(negedge clk) begin
    probe_t p;
    logic [W-1:0] act, e;
    while (probes.size() > 0) begin
      p = probes.pop_front();
      case (p.code)
        0:       act = edit_val;
        1:       act = set_val;
        2:       act = W'(sel);
        3:       act = W'(editing);
        default: act = W'(field_en);
      endcase
      compared++;
      if (act !== p.exp) begin
        mismatched++;
        $display("[TB] FAIL %s: got %0h, expected %0h", p.name, act, p.exp);
      end
    end
    if (set_valid === 1'b1) begin
      compared++;
      if (commits.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_strobe: set_valid=1 set_val=%0h, expected no strobe", set_val);
      end else begin
        e = commits.pop_front();
        if (set_val !== e) begin
          mismatched++;
          $display("[TB] FAIL commit_value: got %0h, expected %0h", set_val, e);
        end
      end
      compared++;
      if (sv_prev === 1'b1) begin
        mismatched++;
        $display("[TB] FAIL strobe_width: set_valid high 2 cycles, expected 1");
      end
    end
    sv_prev = set_valid;
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_editing", 3, 0);
    checkOutput("rst_sel", 2, 0);
    checkOutput("rst_edit_val", 0, 0);
    checkOutput("rst_set_val", 1, 0);
    checkOutput("rst_field_en", 4, 3'b111);
    applyStimulus(B_NONE, 1);
    rst_n = 1'b1;
    applyStimulus(B_NONE, 2);

    // basic edit and commit
    cur_val = pack(12, 34, 56);
    tap(B_NEXT);
    checkOutput("t1_editing", 3, 1);
    checkOutput("t1_load", 0, pack(12, 34, 56));
    tap(B_INC);
    checkOutput("t1_inc", 0, pack(12, 34, 57));
    commits.push_back(pack(12, 34, 57));
    tap(B_CONF);
    checkOutput("t1_editing_off", 3, 0);
    checkOutput("t1_set_val", 1, pack(12, 34, 57));

    // wrap-around at both ends and on the 0..23 field
    cur_val = pack(23, 0, 59);
    tap(B_NEXT);
    tap(B_INC);
    checkOutput("t2_inc_wrap", 0, pack(23, 0, 0));
    tap(B_DEC);
    checkOutput("t2_dec_wrap", 0, pack(23, 0, 59));
    tap(B_NEXT);
    tap(B_NEXT);
    checkOutput("t2_sel2", 2, 2);
    tap(B_INC);
    checkOutput("t2_hour_wrap", 0, pack(0, 0, 59));
    tap(B_DEC);
    checkOutput("t2_hour_dec_wrap", 0, pack(23, 0, 59));
    tap(B_NEXT);
    checkOutput("t2_sel_wrap", 2, 0);
    tap(B_NEXT);
    tap(B_DEC);
    checkOutput("t2_min_dec_wrap", 0, pack(23, 59, 59));
    tap(B_CANC);
    checkOutput("t2_cancel_set_val", 1, pack(12, 34, 57));

    // cancel, and cancel beating confirm
    cur_val = pack(1, 2, 2);
    tap(B_NEXT);
    tap(B_INC);
    checkOutput("t3_edit", 0, pack(1, 2, 3));
    tap(B_CANC);
    checkOutput("t3_cancel_editing", 3, 0);
    checkOutput("t3_cancel_set_val", 1, pack(12, 34, 57));
    tap(B_NEXT);
    tap(B_CONF | B_CANC);
    checkOutput("t3_both_editing", 3, 0);
    checkOutput("t3_both_set_val", 1, pack(12, 34, 57));

    // auto-repeat: 20 sampled-high edges -> steps at h=0,8,10,12,14,16,18
    cur_val = pack(0, 0, 0);
    tap(B_NEXT);
    applyStimulus(B_INC, 20);
    applyStimulus(B_NONE, 1);
    checkOutput("t4_repeat", 0, pack(0, 0, 7));

    // blink on sel=1
    applyStimulus(B_NEXT, 1);
    for (int i = 0; i < 14; i++) begin
      checkOutput($sformatf("t5_blink_%0d", i), 4, ((i / 4) % 2 == 1) ? 3'b101 : 3'b111);
      applyStimulus(B_NONE, 1);
    end
    applyStimulus(B_INC, 1);
    checkOutput("t5_blink_restart", 4, 3'b111);
    checkOutput("t5_inc_field1", 0, pack(0, 1, 7));
    applyStimulus(B_NONE, 1);

    // inc+dec together, reset mid-edit, button held through reset
    tap(B_INC | B_DEC);
    checkOutput("t6_incdec", 0, pack(0, 1, 7));
    applyStimulus(B_NEXT | B_INC, 1);
    rst_n = 1'b0;
    applyStimulus(B_NEXT | B_INC, 1);
    checkOutput("t6_rst_editing", 3, 0);
    checkOutput("t6_rst_edit_val", 0, 0);
    checkOutput("t6_rst_set_val", 1, 0);
    checkOutput("t6_rst_sel", 2, 0);
    checkOutput("t6_rst_field_en", 4, 3'b111);
    rst_n = 1'b1;
    applyStimulus(B_NEXT | B_INC, 3);
    checkOutput("t6_held_no_edge", 3, 0);
    applyStimulus(B_NONE, 1);
    cur_val = pack(5, 6, 7);
    tap(B_NEXT);
    checkOutput("t6_reenter", 0, pack(5, 6, 7));
    tap(B_CANC);
    applyStimulus(B_NONE, 2);

    compared++;
    if (commits.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL missing_commit: %0d pending, expected 0", commits.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
